apb_program_loader: RTL

- APB initiator that drives the core's program-load port (pselect, pwrite, pready, addr_in, data_in, data_out, instruction_load_start).
- Accepts word-granular write and read commands from a host-side valid/ready stream and converts each one into a single APB transfer.
- Returns one response per command.
- Frames a complete program load by holding instruction_load_start high and pulsing load_done when the load finishes.

---
 rtl/apb_program_loader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_program_loader.sv
// -----------------------------------------------------------------------------
// apb_program_loader
//
// Turns host-side load commands into single APB transfers on the core's
// program-load port. Each accepted command produces exactly one response.
// A sequence of commands is framed by instruction_load_start, which rises when
// the first command is accepted and falls after the response to the command
// tagged cmd_last. load_done pulses together with that final response.
//
// Optional feature (macro APB_LOAD_VERIFY_EN):
//   every aligned write is followed by a readback of the same address. The
//   response carries the value read back, and rsp_err flags a mismatch
//   against the written data.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_write/addr/wdata/last command payload
//   rsp_valid/rsp_rdata/err   one-cycle response (rdata 0 for writes)
//   pselect/pwrite/pready     APB control, pready is the access strobe
//   paddr/pwdata/prdata       APB address and data (core addr_in/data_in/data_out)
//   instruction_load_start    load window
//   load_done                 one-cycle pulse at the end of the load
//   dbg_state                 current FSM state, for observation only
// -----------------------------------------------------------------------------
module apb_program_loader #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 32,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_LENGTH-1:0] cmd_addr,
    input  logic [DATA_LENGTH-1:0]    cmd_wdata,
    input  logic                      cmd_last,
    output logic                      rsp_valid,
    output logic [DATA_LENGTH-1:0]    rsp_rdata,
    output logic                      rsp_err,
    output logic                      pselect,
    output logic                      pwrite,
    output logic                      pready,
    output logic [ADDRESS_LENGTH-1:0] paddr,
    output logic [DATA_LENGTH-1:0]    pwdata,
    input  logic [DATA_LENGTH-1:0]    prdata,
    output logic                      instruction_load_start,
    output logic                      load_done,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    // The wait counter counts RD_LATENCY-1 down to 0, so RD_WAIT lasts
    // exactly RD_LATENCY cycles.
    localparam logic [3:0] WAIT_INIT = 4'(RD_LATENCY - 1);

    state_t state, state_next;

    logic                      alive;      // low for the first cycle after reset
    logic                      write_q;
    logic                      last_q;
    logic                      verify_q;   // in the readback pass of a write
    logic                      err_q;
    logic [ADDRESS_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0]    wdata_q;
    logic [DATA_LENGTH-1:0]    rdata_q;
    logic [3:0]                wait_cnt;
    logic                      load_start_q;

    logic accept;
    logic misaligned;
    logic write_pass;  // ACCESS belongs to the write pass of a write command

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high. The source holds cmd_valid and the payload
    // steady until that edge; cmd_ready is only ever high in IDLE.
    assign accept     = cmd_valid && cmd_ready;
    assign misaligned = (cmd_addr[1:0] != 2'b00);
    assign write_pass = write_q && !verify_q;

    assign paddr                  = addr_q;
    assign pwdata                 = wdata_q;
    assign instruction_load_start = load_start_q;
    assign dbg_state              = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        pselect    = 1'b0;
        pready     = 1'b0;
        pwrite     = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        load_done  = 1'b0;

        case (state)
            IDLE: begin
                // Held off for the first cycle after reset so every output
                // reads 0 right after the reset edge.
                cmd_ready = alive;
                if (accept) begin
                    state_next = misaligned ? RESP : SETUP;
                end
            end
            SETUP: begin
                pselect = 1'b1;
                pwrite  = write_pass;
                state_next = ACCESS;
            end
            ACCESS: begin
                pselect = 1'b1;
                pready  = 1'b1;
                pwrite  = write_pass;
                if (write_pass) begin
`ifdef APB_LOAD_VERIFY_EN
                    state_next = SETUP;
`else
                    state_next = RESP;
`endif
                end else begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_q;
                rsp_rdata  = rdata_q;
                load_done  = last_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command latch, read capture, wait counter and load window
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            alive        <= 1'b0;
            write_q      <= 1'b0;
            last_q       <= 1'b0;
            verify_q     <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wait_cnt     <= '0;
            load_start_q <= 1'b0;
        end else begin
            alive <= 1'b1;

            if (accept) begin
                write_q      <= cmd_write;
                last_q       <= cmd_last;
                addr_q       <= cmd_addr;
                wdata_q      <= cmd_wdata;
                verify_q     <= 1'b0;
                rdata_q      <= '0;
                err_q        <= misaligned;
                load_start_q <= 1'b1;
            end

            if (state == ACCESS) begin
                if (write_pass) begin
`ifdef APB_LOAD_VERIFY_EN
                    verify_q <= 1'b1;
`endif
                end else begin
                    wait_cnt <= WAIT_INIT;
                end
            end

            if (state == RD_WAIT) begin
                if (wait_cnt == 4'd0) begin
                    rdata_q <= prdata;
`ifdef APB_LOAD_VERIFY_EN
                    // Only the readback pass of a write is compared.
                    if (write_q) begin
                        err_q <= (prdata != wdata_q);
                    end
`endif
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end

            // The window closes on the edge that ends the final response.
            if (state == RESP && last_q) begin
                load_start_q <= 1'b0;
            end
        end
    end

endmodule
